// File: rtl/can_apb_pkg.sv
// Shared definitions for the multi-channel CAN APB bridge: page encoding,
// global register indices, bridge FSM states and the default ID byte.
package can_apb_pkg;

  localparam logic [3:0] GLOBAL_PAGE    = 4'hF;

  localparam logic [7:0] REG_ID         = 8'h00;
  localparam logic [7:0] REG_IRQ_PEND   = 8'h01;
  localparam logic [7:0] REG_IRQ_MASK   = 8'h02;
  localparam logic [7:0] REG_RST_CTRL   = 8'h03;

  localparam logic [7:0] ID_VAL_DEFAULT = 8'hC2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } bridge_state_e;

  // Place a register byte on the low lane of an APB read word.
  function automatic logic [31:0] apb_byte(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/can_irq_sync.sv
// N-bit two-flop synchroniser for the active-low CAN core interrupt lines.
// Both stages reset to 1 so every line reads as deasserted out of reset.
module can_irq_sync #(
  parameter int N = 2
) (
  input  logic         aclk,
  input  logic         arstn,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_sync
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  // Two-stage capture of the asynchronous lines into the aclk domain.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/can_apb_multi_bridge.sv
// APB slave fronting N_CH byte-wide CAN core register files plus a global
// page (ID, IRQ pending, IRQ mask, per-channel soft reset). Channel writes and
// global accesses complete with zero wait states; channel reads wait RD_LAT
// cycles for the core read data.
module can_apb_multi_bridge
  import can_apb_pkg::*;
#(
  parameter int          N_CH       = 2,
  parameter int          RD_LAT     = 1,
  parameter int          CH_SEL_LSB = 10,
  parameter logic [7:0]  ID_VAL     = ID_VAL_DEFAULT
) (
  input  logic                aclk,
  input  logic                arstn,
  input  logic [31:0]         s_apb_paddr,
  input  logic                s_apb_psel,
  input  logic                s_apb_penable,
  input  logic                s_apb_pwrite,
  input  logic [31:0]         s_apb_pwdata,
  input  logic [3:0]          s_apb_pstrb,
  input  logic [2:0]          s_apb_pprot,
  output logic [31:0]         s_apb_prdata,
  output logic                s_apb_pready,
  output logic                s_apb_pslverr,
  output logic [7:0]          ch_reg_addr_o,
  output logic [7:0]          ch_reg_wdata_o,
  output logic [N_CH-1:0]     ch_reg_we_o,
  output logic [N_CH-1:0]     ch_reg_re_o,
  input  logic [8*N_CH-1:0]   ch_reg_rdata_i,
  output logic [N_CH-1:0]     ch_reg_rst_o,
  input  logic [N_CH-1:0]     ch_irq_n_i,
  output logic                irq_o
);

  localparam logic [3:0] NCH_PAGE  = 4'(N_CH);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  bridge_state_e   r_state;
  logic            r_pready;
  logic            r_pslverr;
  logic [7:0]      r_prdata;
  logic            r_rd_sel;
  logic            r_rd_pend;
  logic [2:0]      r_wait;
  logic [N_CH-1:0] r_ch_oh;
  logic [N_CH-1:0] r_we;
  logic [N_CH-1:0] r_re;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [N_CH-1:0] r_mask;
  logic [N_CH-1:0] r_rst_ctrl;
  logic            r_irq;

  logic [3:0]      w_page;
  logic [7:0]      w_idx;
  logic            w_setup;
  logic            w_is_ch;
  logic [N_CH-1:0] w_ch_hit;
  logic [N_CH-1:0] w_irq_n_sync;
  logic [N_CH-1:0] w_irq_pend;
  logic [7:0]      w_pend_byte;
  logic [7:0]      w_mask_byte;
  logic [7:0]      w_rst_byte;
  logic [7:0]      w_glb_rdata;
  logic [7:0]      w_ch_byte;
  logic            w_unused_ok;

  assign w_page     = s_apb_paddr[CH_SEL_LSB+3:CH_SEL_LSB];
  assign w_idx      = s_apb_paddr[9:2];
  assign w_setup    = s_apb_psel & ~s_apb_penable;
  assign w_is_ch    = (w_page < NCH_PAGE);
  assign w_irq_pend = ~w_irq_n_sync;

  // Upper byte lanes, upper strobes, protection bits and address bits outside
  // the index/page fields carry no meaning for this block.
  assign w_unused_ok = ^{s_apb_pprot, s_apb_pwdata[31:8], s_apb_pstrb[3:1], s_apb_paddr};

  can_irq_sync #(
    .N (N_CH)
  ) u_irq_sync (
    .aclk    (aclk),
    .arstn   (arstn),
    .i_async (ch_irq_n_i),
    .o_sync  (w_irq_n_sync)
  );

  // One-hot decode of the channel page currently on the bus.
  always_comb begin
    w_ch_hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_ch_hit[k] = (w_page == 4'(k));
    end
  end

  // Zero-extend the per-channel global registers to a byte; bits >= N_CH read 0.
  always_comb begin
    w_pend_byte = 8'h00;
    w_mask_byte = 8'h00;
    w_rst_byte  = 8'h00;
    w_pend_byte[N_CH-1:0] = w_irq_pend;
    w_mask_byte[N_CH-1:0] = r_mask;
    w_rst_byte[N_CH-1:0]  = r_rst_ctrl;
  end

  // Global page read mux; unknown indices read as zero.
  always_comb begin
    w_glb_rdata = 8'h00;
    case (w_idx)
      REG_ID:       w_glb_rdata = ID_VAL;
      REG_IRQ_PEND: w_glb_rdata = w_pend_byte;
      REG_IRQ_MASK: w_glb_rdata = w_mask_byte;
      REG_RST_CTRL: w_glb_rdata = w_rst_byte;
      default:      w_glb_rdata = 8'h00;
    endcase
  end

  // Read byte of the channel selected at setup time.
  always_comb begin
    w_ch_byte = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      w_ch_byte = w_ch_byte | (r_ch_oh[k] ? ch_reg_rdata_i[8*k +: 8] : 8'h00);
    end
  end

  // Bridge FSM: decode in SETUP, pulse the core in the first ACCESS cycle,
  // count read latency, complete and fall back to IDLE.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= IDLE;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= 8'h00;
      r_rd_sel   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_wait     <= 3'd0;
      r_ch_oh    <= '0;
      r_we       <= '0;
      r_re       <= '0;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_mask     <= '0;
      r_rst_ctrl <= '0;
    end else begin
      r_we <= '0;
      r_re <= '0;
      case (r_state)
        IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_rd_sel  <= 1'b0;
          r_rd_pend <= 1'b0;
          r_wait    <= 3'd0;
          if (w_setup) begin
            r_state  <= ACCESS;
            r_addr   <= w_idx;
            r_wdata  <= s_apb_pwdata[7:0];
            r_ch_oh  <= w_ch_hit;
            r_prdata <= 8'h00;
            if (w_is_ch) begin
              if (s_apb_pwrite) begin
                r_pready <= 1'b1;
                r_we     <= s_apb_pstrb[0] ? w_ch_hit : '0;
              end else begin
                r_re      <= w_ch_hit;
                r_rd_pend <= 1'b1;
              end
            end else if (w_page == GLOBAL_PAGE) begin
              r_pready <= 1'b1;
              if (s_apb_pwrite) begin
                if (s_apb_pstrb[0]) begin
                  case (w_idx)
                    REG_IRQ_MASK: r_mask     <= s_apb_pwdata[N_CH-1:0];
                    REG_RST_CTRL: r_rst_ctrl <= s_apb_pwdata[N_CH-1:0];
                    default:      r_mask     <= r_mask;
                  endcase
                end else begin
                  r_mask <= r_mask;
                end
              end else begin
                r_prdata <= w_glb_rdata;
              end
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (!s_apb_psel) begin
            // Master abandoned the transfer; an issued read pulse stays issued.
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wait    <= 3'd0;
          end else if (r_pready) begin
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_sel  <= 1'b0;
          end else if (r_rd_pend) begin
            if (r_wait == WAIT_LAST) begin
              r_pready  <= 1'b1;
              r_rd_sel  <= 1'b1;
              r_rd_pend <= 1'b0;
              r_wait    <= 3'd0;
            end else begin
              r_wait <= r_wait + 3'd1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Aggregated interrupt: synchronised pending lines qualified by the mask.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_irq_pend & r_mask);
    end
  end

  // The channel read byte is only valid in the completing cycle, so it is
  // steered through directly under a registered select; everything else is
  // a register.
  assign s_apb_prdata   = r_rd_sel ? apb_byte(w_ch_byte) : apb_byte(r_prdata);
  assign s_apb_pready   = r_pready;
  assign s_apb_pslverr  = r_pslverr;
  assign ch_reg_addr_o  = r_addr;
  assign ch_reg_wdata_o = r_wdata;
  assign ch_reg_we_o    = r_we;
  assign ch_reg_re_o    = r_re;
  assign ch_reg_rst_o   = r_rst_ctrl;
  assign irq_o          = r_irq;

endmodule

// File: tb/tb_can_apb_multi_bridge.sv
// Directed bench for can_apb_multi_bridge with N_CH=2, RD_LAT=2. The two CAN
// cores are modelled as fixed read bytes that appear exactly RD_LAT cycles
// after the read pulse and read as 0xEE otherwise.
module tb_can_apb_multi_bridge;

  logic        aclk;
  logic        arstn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [1:0]  reg_we;
  logic [1:0]  reg_re;
  logic [15:0] reg_rdata;
  logic [1:0]  reg_rst;
  logic [1:0]  irq_n;
  logic        irq;

  logic [1:0]  rp0 = 2'b00;
  logic [1:0]  rp1 = 2'b00;
  int          we_cnt0 = 0;
  int          we_cnt1 = 0;
  int          re_cnt0 = 0;
  int          re_cnt1 = 0;

  int          n_cmp = 0;
  int          n_bad = 0;

  can_apb_multi_bridge #(
    .N_CH       (2),
    .RD_LAT     (2),
    .CH_SEL_LSB (10),
    .ID_VAL     (8'hC2)
  ) dut (
    .aclk           (aclk),
    .arstn          (arstn),
    .s_apb_paddr    (paddr),
    .s_apb_psel     (psel),
    .s_apb_penable  (penable),
    .s_apb_pwrite   (pwrite),
    .s_apb_pwdata   (pwdata),
    .s_apb_pstrb    (pstrb),
    .s_apb_pprot    (pprot),
    .s_apb_prdata   (prdata),
    .s_apb_pready   (pready),
    .s_apb_pslverr  (pslverr),
    .ch_reg_addr_o  (reg_addr),
    .ch_reg_wdata_o (reg_wdata),
    .ch_reg_we_o    (reg_we),
    .ch_reg_re_o    (reg_re),
    .ch_reg_rdata_i (reg_rdata),
    .ch_reg_rst_o   (reg_rst),
    .ch_irq_n_i     (irq_n),
    .irq_o          (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Core read model: data valid exactly two cycles after the read pulse.
  always @(posedge aclk) begin
    rp0 <= reg_re;
    rp1 <= rp0;
  end
  assign reg_rdata = {(rp1[1] ? 8'h77 : 8'hEE), (rp1[0] ? 8'h3C : 8'hEE)};

  // Pulse counters sampled mid-cycle.
  always @(negedge aclk) begin
    if (reg_we[0]) we_cnt0 <= we_cnt0 + 1;
    if (reg_we[1]) we_cnt1 <= we_cnt1 + 1;
    if (reg_re[0]) re_cnt0 <= re_cnt0 + 1;
    if (reg_re[1]) re_cnt1 <= re_cnt1 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer starting just after a rising edge; returns read data,
  // error flag and the number of ACCESS cycles up to and including pready.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [7:0] wd,
                          input logic [3:0] strb, output logic [31:0] rd,
                          output logic err, output int acc);
    logic done;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = {24'hA5A5A5, wd};
    pstrb   = strb;
    @(posedge aclk); #1;
    penable = 1'b1;
    acc  = 0;
    done = 1'b0;
    rd   = 32'hFFFF_FFFF;
    err  = 1'b1;
    while (!done && acc < 16) begin
      @(negedge aclk);
      acc++;
      if (pready) begin
        rd   = prdata;
        err  = pslverr;
        done = 1'b1;
      end
    end
    if (!done) check_eq("pready_timeout", 32'd0, 32'd1);
    @(posedge aclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          acc;
  int          s_we0, s_we1, s_re0, s_re1;

  task automatic snap();
    s_we0 = we_cnt0; s_we1 = we_cnt1; s_re0 = re_cnt0; s_re1 = re_cnt1;
  endtask

  initial begin
    arstn   = 1'b0;
    paddr   = 32'h0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pwdata  = 32'h0;
    pstrb   = 4'h0;
    pprot   = 3'b000;
    irq_n   = 2'b11;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_pready",  32'(pready), 32'd0);
    check_eq("rst_pslverr", 32'(pslverr), 32'd0);
    check_eq("rst_prdata",  prdata, 32'h0);
    check_eq("rst_we_re",   32'({reg_we, reg_re}), 32'd0);
    check_eq("rst_rst_irq", 32'({reg_rst, irq}), 32'd0);
    check_eq("rst_addr",    32'(reg_addr), 32'd0);
    @(posedge aclk); #1;
    arstn = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // Channel 1 write, index 4
    snap();
    apb_xfer(32'h0000_0410, 1'b1, 8'h5A, 4'h1, rd, err, acc);
    check_eq("wr1_we1",   32'(we_cnt1 - s_we1), 32'd1);
    check_eq("wr1_we0",   32'(we_cnt0 - s_we0), 32'd0);
    check_eq("wr1_addr",  32'(reg_addr), 32'h04);
    check_eq("wr1_wdata", 32'(reg_wdata), 32'h5A);
    check_eq("wr1_lat",   32'(acc), 32'd1);
    check_eq("wr1_err",   32'(err), 32'd0);

    // Channel 0 write with byte strobe off
    snap();
    apb_xfer(32'h0000_0008, 1'b1, 8'h11, 4'hE, rd, err, acc);
    check_eq("wrns_we0", 32'(we_cnt0 - s_we0), 32'd0);
    check_eq("wrns_lat", 32'(acc), 32'd1);
    check_eq("wrns_err", 32'(err), 32'd0);

    // Channel 0 read, index 2
    snap();
    apb_xfer(32'h0000_0008, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("rd0_re0",  32'(re_cnt0 - s_re0), 32'd1);
    check_eq("rd0_re1",  32'(re_cnt1 - s_re1), 32'd0);
    check_eq("rd0_lat",  32'(acc), 32'd3);
    check_eq("rd0_data", rd, 32'h0000_003C);
    check_eq("rd0_addr", 32'(reg_addr), 32'h02);

    // Channel 1 read, index 5
    snap();
    apb_xfer(32'h0000_0414, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("rd1_re1",  32'(re_cnt1 - s_re1), 32'd1);
    check_eq("rd1_data", rd, 32'h0000_0077);
    check_eq("rd1_lat",  32'(acc), 32'd3);

    // Global ID
    apb_xfer(32'h0000_3C00, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("id_data", rd, 32'h0000_00C2);
    check_eq("id_lat",  32'(acc), 32'd1);

    // IRQ pending with mask clear
    irq_n = 2'b10;
    repeat (3) @(posedge aclk); #1;
    apb_xfer(32'h0000_3C04, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("pend_data", rd, 32'h0000_0001);
    check_eq("pend_irq",  32'(irq), 32'd0);
    irq_n = 2'b11;

    // Mask readback clips to N_CH bits
    apb_xfer(32'h0000_3C08, 1'b1, 8'hFF, 4'h1, rd, err, acc);
    apb_xfer(32'h0000_3C08, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("mask_rb", rd, 32'h0000_0003);

    // IRQ latency with mask = ch0
    apb_xfer(32'h0000_3C08, 1'b1, 8'h01, 4'h1, rd, err, acc);
    repeat (3) @(posedge aclk);
    check_eq("irq_idle", 32'(irq), 32'd0);
    #1;
    irq_n = 2'b10;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_eq("irq_lat2", 32'(irq), 32'd0);
    @(negedge aclk);
    check_eq("irq_lat3", 32'(irq), 32'd1);
    @(posedge aclk); #1;
    apb_xfer(32'h0000_3C08, 1'b1, 8'h00, 4'h1, rd, err, acc);
    check_eq("irq_unmask", 32'(irq), 32'd0);

    // Soft reset control; IRQ still reported for channels in reset
    apb_xfer(32'h0000_3C0C, 1'b1, 8'h03, 4'h1, rd, err, acc);
    check_eq("rst_out", 32'(reg_rst), 32'd3);
    apb_xfer(32'h0000_3C04, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("pend_inrst", rd, 32'h0000_0001);
    apb_xfer(32'h0000_3C0C, 1'b1, 8'h01, 4'h1, rd, err, acc);
    apb_xfer(32'h0000_3C0C, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("rst_rb", rd, 32'h0000_0001);
    check_eq("rst_out2", 32'(reg_rst), 32'd1);

    // Unknown global index: write ignored, reads zero, no error
    apb_xfer(32'h0000_3C40, 1'b1, 8'hFF, 4'h1, rd, err, acc);
    check_eq("unk_werr", 32'(err), 32'd0);
    apb_xfer(32'h0000_3C40, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("unk_data", rd, 32'h0);
    check_eq("unk_rerr", 32'(err), 32'd0);

    // Unmapped page 5
    snap();
    apb_xfer(32'h0000_1400, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("bad_err",  32'(err), 32'd1);
    check_eq("bad_lat",  32'(acc), 32'd1);
    check_eq("bad_data", rd, 32'h0);
    apb_xfer(32'h0000_1400, 1'b1, 8'h99, 4'h1, rd, err, acc);
    check_eq("bad_werr", 32'(err), 32'd1);
    check_eq("bad_pulses", 32'((we_cnt0 - s_we0) + (we_cnt1 - s_we1) + (re_cnt0 - s_re0) + (re_cnt1 - s_re1)), 32'd0);

    // Reset during a read wait state
    apb_xfer(32'h0000_3C08, 1'b1, 8'h01, 4'h1, rd, err, acc);
    check_eq("pre_rst_irq", 32'(irq), 32'd1);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = 32'h0000_0008;
    pwrite  = 1'b0;
    pstrb   = 4'h0;
    @(posedge aclk); #1;
    penable = 1'b1;
    @(negedge aclk);
    check_eq("abort_re0", 32'(reg_re), 32'd1);
    @(posedge aclk); #3;
    arstn = 1'b0;
    #1;
    check_eq("arst_pready", 32'(pready), 32'd0);
    check_eq("arst_we_re",  32'({reg_we, reg_re}), 32'd0);
    check_eq("arst_irq",    32'(irq), 32'd0);
    check_eq("arst_rst",    32'(reg_rst), 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge aclk); #1;
    arstn = 1'b1;
    repeat (4) @(posedge aclk); #1;
    snap();
    apb_xfer(32'h0000_0008, 1'b0, 8'h00, 4'h0, rd, err, acc);
    check_eq("post_rd_data", rd, 32'h0000_003C);
    check_eq("post_rd_lat",  32'(acc), 32'd3);
    check_eq("post_rd_re0",  32'(re_cnt0 - s_re0), 32'd1);
    check_eq("post_irq",     32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
